// File: rtl/mem_pkg.sv
// Shared definitions for the data-RAM port arbiter: FSM states and the
// hardware-owned status slot map at the bottom of the RAM.
package mem_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    ACK   = 2'd2,
    RDATA = 2'd3
  } arb_state_t;

  localparam int NEWGAME_ADDR  = 0;
  localparam int DISTANCE_ADDR = 1;
  localparam int GOACT_ADDR    = 2;

  // Everything up to and including the last status slot is hardware-owned.
  localparam int RESERVED_TOP_DEF = GOACT_ADDR + 1;

  function automatic int starve_width(input int limit);
    return $clog2(limit + 1);
  endfunction

endpackage

// File: rtl/ram_port_arbiter.sv
// Shares the single data-RAM port between the CPU memory stage (priority) and
// one peripheral master, with a starvation counter that forces a peripheral slot.
module ram_port_arbiter
  import mem_pkg::*;
#(
  parameter int DATA_WIDTH    = 32,
  parameter int ADDRESS_WIDTH = 12,
  parameter int STARVE_LIMIT  = 4,
  parameter int RESERVED_TOP  = RESERVED_TOP_DEF
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     cpu_req,
  input  logic                     cpu_we,
  input  logic [ADDRESS_WIDTH-1:0] cpu_addr,
  input  logic [DATA_WIDTH-1:0]    cpu_wdata,
  output logic [DATA_WIDTH-1:0]    cpu_rdata,
  output logic                     cpu_stall,
  input  logic                     p_req,
  input  logic                     p_we,
  input  logic [ADDRESS_WIDTH-1:0] p_addr,
  input  logic [DATA_WIDTH-1:0]    p_wdata,
  output logic                     p_ack,
  output logic [DATA_WIDTH-1:0]    p_rdata,
  output logic                     p_err,
  output logic                     ram_wEn,
  output logic [ADDRESS_WIDTH-1:0] ram_addr,
  output logic [DATA_WIDTH-1:0]    ram_dataIn,
  input  logic [DATA_WIDTH-1:0]    ram_dataOut
);

  localparam int CW = starve_width(STARVE_LIMIT);
  localparam logic [CW-1:0]            LIMIT = CW'(STARVE_LIMIT);
  localparam logic [ADDRESS_WIDTH-1:0] RSV   = ADDRESS_WIDTH'(RESERVED_TOP);

  arb_state_t            state;
  logic [CW-1:0]         starve_cnt;
  logic [DATA_WIDTH-1:0] p_rdata_q;

  logic p_rej;
  logic p_grant;
  logic cpu_grant;

  assign p_rej = p_we && (p_addr < RSV);

  // Peripheral is only considered in IDLE/WAIT; ACK/RDATA always belong to the CPU.
  always_comb begin
    p_grant   = 1'b0;
    cpu_stall = 1'b0;
    unique case (state)
      IDLE: p_grant = p_req && !cpu_req;
      WAIT: begin
        if (p_req) begin
          if (!cpu_req) begin
            p_grant = 1'b1;
          end else if (starve_cnt == LIMIT) begin
            p_grant   = 1'b1;
            cpu_stall = 1'b1;
          end
        end
      end
      ACK:   ;
      RDATA: ;
    endcase
  end

  // A forced peripheral slot always stalls the CPU, so the two grants are exclusive.
  assign cpu_grant = cpu_req && !p_grant;

  always_comb begin
    ram_addr   = cpu_addr;
    ram_dataIn = cpu_wdata;
    ram_wEn    = cpu_grant && cpu_we;
    if (p_grant) begin
      ram_addr   = p_addr;
      ram_dataIn = p_wdata;
      ram_wEn    = p_we && !p_rej;
    end
  end

  assign cpu_rdata = ram_dataOut;
  // The RAM output is the peripheral's read word during RDATA; hold it afterwards.
  assign p_rdata   = (state == RDATA) ? ram_dataOut : p_rdata_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      starve_cnt <= '0;
      p_ack      <= 1'b0;
      p_err      <= 1'b0;
      p_rdata_q  <= '0;
    end else begin
      p_ack <= 1'b0;
      p_err <= 1'b0;
      if (state == RDATA) p_rdata_q <= ram_dataOut;
      unique case (state)
        IDLE, WAIT: begin
          if (p_grant) begin
            state      <= p_we ? ACK : RDATA;
            starve_cnt <= '0;
            p_ack      <= 1'b1;
            p_err      <= p_rej;
          end else if (p_req) begin
            state      <= WAIT;
            starve_cnt <= (state == IDLE) ? CW'(1) : starve_cnt + CW'(1);
          end else begin
            state      <= IDLE;
            starve_cnt <= '0;
          end
        end
        ACK, RDATA: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Randomized and directed bench for ram_port_arbiter against a transaction-level
// model: a reference memory plus a count of cycles the peripheral has been denied.
module tb_ram_port_arbiter;
  localparam int DW  = 32;
  localparam int AW  = 12;
  localparam int LIM = 4;
  localparam int RT  = 3;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          cpu_req = 1'b0, cpu_we = 1'b0;
  logic [AW-1:0] cpu_addr = '0;
  logic [DW-1:0] cpu_wdata = '0;
  logic [DW-1:0] cpu_rdata;
  logic          cpu_stall;
  logic          p_req = 1'b0, p_we = 1'b0;
  logic [AW-1:0] p_addr = '0;
  logic [DW-1:0] p_wdata = '0;
  logic          p_ack, p_err;
  logic [DW-1:0] p_rdata;
  logic          ram_wEn;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_dataIn;
  logic [DW-1:0] ram_dataOut;

  always #5 clk = ~clk;

  ram_port_arbiter #(.DATA_WIDTH(DW), .ADDRESS_WIDTH(AW), .STARVE_LIMIT(LIM), .RESERVED_TOP(RT)) dut (
    .clk(clk), .reset(reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
    .p_req(p_req), .p_we(p_we), .p_addr(p_addr), .p_wdata(p_wdata),
    .p_ack(p_ack), .p_rdata(p_rdata), .p_err(p_err),
    .ram_wEn(ram_wEn), .ram_addr(ram_addr), .ram_dataIn(ram_dataIn), .ram_dataOut(ram_dataOut)
  );

  // Slot 1 stands in for the hardware distance value, slot 5 for preloaded data.
  function automatic logic [DW-1:0] init_val(input int a);
    if (a == 5) return 32'h0000_1234;
    if (a == 1) return 32'd77;
    return 32'hC0DE_0000 | DW'(a);
  endfunction

  logic [DW-1:0] mem [0:(1<<AW)-1];
  logic          fill = 1'b1;
  int            wr_cnt;

  always @(posedge clk) begin
    if (fill) begin
      for (int i = 0; i < (1 << AW); i++) mem[i] <= init_val(i);
      wr_cnt <= 0;
    end else begin
      if (ram_wEn) begin
        mem[ram_addr] <= ram_dataIn;
        wr_cnt        <= wr_cnt + 1;
      end
      ram_dataOut <= mem[ram_addr];
    end
  end

  logic [DW-1:0] ref_mem [0:(1<<AW)-1];
  int n_chk = 0, n_pass = 0;
  int mode = 0;
  int denied = 0;
  logic m_busy = 0, exp_ack = 0, exp_err = 0, exp_prd_chk = 0, cpu_rd_chk = 0;
  logic [DW-1:0] exp_prd = '0, cpu_rd_exp = '0;
  logic stall_hold = 0, dut_stall_prev = 0, m_acked = 0;
  logic last_ack = 0, last_err = 0;
  logic [DW-1:0] last_prd = '0, last_rd = '0;

  task automatic chk(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // CPU stimulus per mode; a stalled CPU repeats its request unchanged.
  task automatic cpu_pick();
    if (stall_hold) return;
    case (mode)
      0: cpu_req = 1'b0;
      1: begin
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = AW'($urandom_range(0, 31));
      end
      2: begin
        cpu_req   = 1'($urandom_range(0, 1));
        cpu_we    = 1'($urandom_range(0, 1));
        cpu_addr  = AW'($urandom_range(0, 31));
        cpu_wdata = $urandom;
      end
      default: ;
    endcase
  endtask

  // One clock: predict, check at negedge, then advance the model.
  task automatic cycle();
    logic pserve, rej, stall_e, we_e;
    cpu_pick();
    pserve  = !m_busy && p_req && (!cpu_req || denied == LIM);
    rej     = p_we && (p_addr < RT);
    stall_e = pserve && cpu_req;
    we_e    = pserve ? (p_we && !rej) : (cpu_req && cpu_we);
    @(negedge clk);
    chk("cpu_stall", cpu_stall, stall_e);
    chk("stall_twice", dut_stall_prev & cpu_stall, 0);
    chk("p_ack", p_ack, exp_ack);
    if (exp_ack) chk("p_err", p_err, exp_err);
    if (exp_ack && exp_prd_chk) chk("p_rdata", p_rdata, exp_prd);
    if (cpu_rd_chk) chk("cpu_rdata", cpu_rdata, cpu_rd_exp);
    chk("ram_wEn", ram_wEn, we_e);
    if (we_e) chk("ram_addr", ram_addr, pserve ? p_addr : cpu_addr);
    dut_stall_prev = cpu_stall;
    last_ack = p_ack; last_err = p_err; last_prd = p_rdata; last_rd = cpu_rdata;
    m_acked     = exp_ack;
    exp_ack     = pserve;
    exp_err     = pserve && rej;
    exp_prd_chk = pserve && !p_we;
    exp_prd     = ref_mem[p_addr];
    cpu_rd_chk  = cpu_req && !cpu_we && !stall_e;
    cpu_rd_exp  = ref_mem[cpu_addr];
    if (pserve) begin
      if (p_we && !rej) ref_mem[p_addr] = p_wdata;
    end else if (cpu_req && cpu_we) begin
      ref_mem[cpu_addr] = cpu_wdata;
    end
    if (pserve) denied = 0;
    else if (!m_busy && p_req) denied++;
    else denied = 0;
    m_busy     = pserve;
    stall_hold = stall_e;
    @(posedge clk); #1;
  endtask

  // Peripheral transaction held until acked; stall_at = -2 skips the stall-position check.
  task automatic p_xact(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d,
                        input int stall_at, output int lat);
    int n, seen_stall, dut_lat;
    bit done;
    p_req = 1'b1; p_we = we; p_addr = a; p_wdata = d;
    n = 0; done = 0; seen_stall = -1; dut_lat = -1;
    while (!done && n < 20) begin
      cycle();
      if (dut_stall_prev && seen_stall < 0) seen_stall = n;
      if (last_ack && dut_lat < 0) dut_lat = n;
      if (m_acked) done = 1;
      n++;
    end
    chk("p_done", 32'(done), 1);
    chk("p_ack_bound", 32'(dut_lat >= 0 && dut_lat <= LIM + 1), 1);
    if (stall_at != -2) chk("stall_pos", seen_stall, stall_at);
    p_req = 1'b0;
    lat = n;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    m_busy = 0; denied = 0; exp_ack = 0; cpu_rd_chk = 0; stall_hold = 0; dut_stall_prev = 0;
    chk("rst_p_ack", p_ack, 0);
    chk("rst_p_err", p_err, 0);
    chk("rst_p_rdata", p_rdata, 0);
  endtask

  initial begin
    #300000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1);
  end

  initial begin
    int lat, tot, w0;
    for (int i = 0; i < (1 << AW); i++) ref_mem[i] = init_val(i);
    @(posedge clk); #1;
    fill = 1'b0;
    chk("rst_p_ack", p_ack, 0);
    chk("rst_p_err", p_err, 0);
    chk("rst_p_rdata", p_rdata, 0);
    chk("rst_stall", cpu_stall, 0);
    @(posedge clk); #1;
    reset = 1'b0;

    // Idle CPU, peripheral write, then CPU reads it back.
    mode = 0;
    p_xact(1'b1, 12'd10, 32'hDEAD, -1, lat);
    chk("wr_lat", lat, 2);
    chk("wr_err", last_err, 0);
    mode = 3;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 12'd10;
    cycle();
    cpu_req = 1'b0;
    cycle();
    chk("rd10", last_rd, 32'hDEAD);

    // CPU busy every cycle: peripheral forced in after LIM denials.
    mode = 1;
    p_xact(1'b0, 12'd5, '0, LIM, lat);
    chk("starve_lat", lat, LIM + 2);
    chk("rd5", last_prd, 32'h1234);

    // Write into the distance slot is rejected.
    mode = 0;
    w0 = wr_cnt;
    p_xact(1'b1, 12'd1, 32'hBAD0BAD0, -1, lat);
    chk("rsv_err", last_err, 1);
    chk("rsv_nowrite", wr_cnt - w0, 0);
    mode = 3;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 12'd1;
    cycle();
    cpu_req = 1'b0;
    cycle();
    chk("rd1", last_rd, 32'd77);

    // Back-to-back peripheral writes.
    mode = 0;
    w0 = wr_cnt; tot = 0;
    for (int i = 0; i < 4; i++) begin
      p_xact(1'b1, AW'(16 + i), $urandom, -1, lat);
      tot += lat;
    end
    chk("b2b_cycles", tot, 8);
    chk("b2b_writes", wr_cnt - w0, 4);

    // Reset while waiting: counter restarts from zero afterwards.
    mode = 1;
    p_req = 1'b1; p_we = 1'b0; p_addr = 12'd7;
    cycle();
    cycle();
    do_reset();
    p_xact(1'b0, 12'd7, '0, LIM, lat);
    chk("rst_wait_lat", lat, LIM + 2);

    // Reset during the read-data cycle: held request completes again.
    mode = 0;
    p_req = 1'b1; p_we = 1'b0; p_addr = 12'd9;
    cycle();
    do_reset();
    p_xact(1'b0, 12'd9, '0, -1, lat);
    chk("rst_rdata_lat", lat, 2);

    // Random mixed traffic.
    mode = 2;
    for (int t = 0; t < 150; t++) begin
      int gap;
      gap = $urandom_range(0, 3);
      for (int g = 0; g < gap; g++) cycle();
      p_xact(1'($urandom_range(0, 1)), AW'($urandom_range(0, 31)), $urandom, -2, lat);
    end
    mode = 0;
    cycle();
    cycle();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
